// File: rtl/pipelined_segmented_adder.sv
// rtl/pipelined_segmented_adder.sv - carry-chained segmented adder pipeline, valid/ready handshake, optional PIPELINED_ADDER_OVF_EN overflow flag
module pipelined_segmented_adder #(
  parameter int W     = 32,
  parameter int N_SEG = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         cout,
  output logic [W-1:0] y
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int S = W / N_SEG;

  if ((N_SEG < 1) || (N_SEG > W)) begin : g_bad_nseg
    $fatal(1, "pipelined_segmented_adder: N_SEG must be in 1..W");
  end else if ((W % N_SEG) != 0) begin : g_bad_width
    $fatal(1, "pipelined_segmented_adder: W must be a multiple of N_SEG");
  end

  // Per-stage entry: valid, carry out of the newest slice, full operands and partial sum.
  logic [N_SEG-1:0] v_q, v_d;
  logic [N_SEG-1:0] c_q, c_d;
  logic [W-1:0]     a_q [N_SEG];
  logic [W-1:0]     a_d [N_SEG];
  logic [W-1:0]     b_q [N_SEG];
  logic [W-1:0]     b_d [N_SEG];
  logic [W-1:0]     y_q [N_SEG];
  logic [W-1:0]     y_d [N_SEG];
  logic [N_SEG-1:0] ld;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             src_v;
  logic             src_c;
  logic [W-1:0]     src_a;
  logic [W-1:0]     src_b;
  logic [W-1:0]     src_y;
  logic [S:0]       seg;

  // Load enables ripple back from out_rdy; each stage adds its slice and shifts the entry forward.
  always_comb begin
    ld    = '0;
    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    y_d   = y_q;
    src_v = 1'b0;
    src_c = 1'b0;
    src_a = '0;
    src_b = '0;
    src_y = '0;
    seg   = '0;
`ifdef PIPELINED_ADDER_OVF_EN
    ovf_d = ovf_q;
`endif

    // A stage may load when empty or when its occupant moves on this cycle.
    ld[N_SEG-1] = ~v_q[N_SEG-1] | out_rdy;
    for (int k = N_SEG - 2; k >= 0; k--) begin
      ld[k] = ~v_q[k] | ld[k+1];
    end

    for (int k = 0; k < N_SEG; k++) begin
      if (k == 0) begin
        src_v = in_vld;
        src_c = cin;
        src_a = a;
        src_b = b;
        src_y = '0;
      end else begin
        src_v = v_q[(k > 0) ? k - 1 : 0];
        src_c = c_q[(k > 0) ? k - 1 : 0];
        src_a = a_q[(k > 0) ? k - 1 : 0];
        src_b = b_q[(k > 0) ? k - 1 : 0];
        src_y = y_q[(k > 0) ? k - 1 : 0];
      end

      seg = {1'b0, src_a[k*S +: S]} + {1'b0, src_b[k*S +: S]} + {{S{1'b0}}, src_c};

      if (ld[k]) begin
        v_d[k] = src_v;
      end

      // Data only changes when a real entry arrives, so outputs hold across bubbles.
      if (ld[k] && src_v) begin
        a_d[k]            = src_a;
        b_d[k]            = src_b;
        y_d[k]            = src_y;
        y_d[k][k*S +: S]  = seg[S-1:0];
        c_d[k]            = seg[S];
`ifdef PIPELINED_ADDER_OVF_EN
        if (k == N_SEG - 1) begin
          ovf_d = (src_a[W-1] == src_b[W-1]) & (seg[S-1] != src_a[W-1]);
        end
`endif
      end
    end
  end

  // Pipeline state; everything clears on reset so outputs are defined immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < N_SEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        y_q[k] <= '0;
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      y_q <= y_d;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_rdy  = ld[0];
  assign out_vld = v_q[N_SEG-1];
  assign y       = y_q[N_SEG-1];
  assign cout    = c_q[N_SEG-1];
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// tb/tb_pipelined_segmented_adder.sv - scoreboard bench for pipelined_segmented_adder
module tb_pipelined_segmented_adder #(
  parameter int N_SEG = 4
);

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_vld;
  logic         out_rdy = 1'b1;
  logic         cout;
  logic [W-1:0] y;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_segmented_adder #(.W(W), .N_SEG(N_SEG)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .cin     (cin),
    .a       (a),
    .b       (b),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .cout    (cout),
    .y       (y)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Hand-computed vectors: {vco,vy} = va + vb + vci, vov = signed overflow.
  bit [31:0] va  [12] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000,
                          32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h00FF_00FF,
                          32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h0000_0001, 32'h4000_0000};
  bit [31:0] vb  [12] = '{32'h0000_0001, 32'h0000_0000, 32'h8765_4321, 32'h8000_0000,
                          32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FF01,
                          32'h0123_4567, 32'h5A5A_5A5A, 32'hFFFF_FFFE, 32'h4000_0000};
  bit        vci [12] = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
  bit [31:0] vy  [12] = '{32'h0000_0000, 32'h0000_0001, 32'h9999_9999, 32'h0000_0000,
                          32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0100_0000,
                          32'hDFD1_0457, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
  bit        vco [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
  bit        vov [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         o;
    int           acc;
    bit           lat;
    bit           gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_emit = -100;
  int   acc_cnt = 0;
  int   stall_waits = 0;
  int   rdy_mode = 0;
  bit   lat_en = 1'b0;
  bit   gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present vector i until accepted, then queue its expected result.
  task automatic send(input int i);
    int   w;
    exp_t e;
    in_vld = 1'b1;
    a      = va[i];
    b      = vb[i];
    cin    = vci[i];
    w      = 0;
    @(negedge clk);
    while (!in_rdy && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (in_rdy) begin
      e.y   = vy[i];
      e.c   = vco[i];
      e.o   = vov[i];
      e.acc = cyc;
      e.lat = lat_en;
      e.gap = gap_en;
      exp_q.push_back(e);
      acc_cnt++;
    end else begin
      check(1'b0, "accept_timeout", 64'(i), 64'(i));
    end
    stall_waits += w;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  // Monitor: every transfer on the output side pops and compares one expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (arst_n && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_output", 64'(y), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(y === e.y, "y", 64'(y), 64'(e.y));
        check(cout === e.c, "cout", 64'(cout), 64'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
        check(ovf === e.o, "ovf", 64'(ovf), 64'(e.o));
`endif
        if (e.lat) check((cyc - e.acc) == N_SEG, "latency", 64'(cyc - e.acc), 64'(N_SEG));
        if (e.gap) check((cyc - last_emit) == 1, "emit_gap", 64'(cyc - last_emit), 64'd1);
        last_emit = cyc;
      end
    end
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(out_vld === 1'b0, "rst_out_vld", 64'(out_vld), 64'd0);
    arst_n = 1'b1;
    @(negedge clk);
    check(out_vld === 1'b0, "post_rst_out_vld", 64'(out_vld), 64'd0);
    check(y === '0, "post_rst_y", 64'(y), 64'd0);
    check(cout === 1'b0, "post_rst_cout", 64'(cout), 64'd0);
    check(in_rdy === 1'b1, "post_rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Ripple through every segment, latency N_SEG
    lat_en = 1'b1;
    send(0);
    idle(N_SEG + 2);
    send(1);
    idle(N_SEG + 2);
    check(exp_q.size() == 0, "ripple_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back streaming
    stall_waits = 0;
    for (int i = 2; i < 10; i++) begin
      gap_en = (i > 2);
      send(i);
    end
    gap_en = 1'b0;
    check(stall_waits == 0, "stream_in_rdy", 64'(stall_waits), 64'd0);
    idle(N_SEG + 2);
    check(exp_q.size() == 0, "stream_drained", 64'(exp_q.size()), 64'd0);
    lat_en = 1'b0;

    // Backpressure: pipe absorbs N_SEG entries, outputs hold, then all drain in order
    rdy_mode = 2;
    idle(2);
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          gap_en = (i > 0);
          send(i);
        end
      end
      begin
        idle(N_SEG + 4);
        check(acc_cnt == ((N_SEG < 6) ? N_SEG : 6), "stall_accepts", 64'(acc_cnt), 64'((N_SEG < 6) ? N_SEG : 6));
        check(in_rdy === ((N_SEG <= 6) ? 1'b0 : 1'b1), "stall_in_rdy", 64'(in_rdy), 64'((N_SEG <= 6) ? 0 : 1));
        repeat (3) begin
          @(negedge clk);
          check(out_vld === 1'b1, "stall_out_vld", 64'(out_vld), 64'd1);
          check(y === exp_q[0].y, "stall_y", 64'(y), 64'(exp_q[0].y));
          check(cout === exp_q[0].c, "stall_cout", 64'(cout), 64'(exp_q[0].c));
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        out_rdy  = 1'b1;
      end
    join
    idle(N_SEG + 8);
    gap_en = 1'b0;
    check(exp_q.size() == 0, "backpressure_drained", 64'(exp_q.size()), 64'd0);

    // Bubbles with random consumer readiness
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      send(i);
      idle(1);
    end
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      idle(1);
      t++;
    end
    check(exp_q.size() == 0, "bubble_drained", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;
    idle(2);

    // Reset with entries in flight
    rdy_mode = 2;
    idle(2);
    for (int i = 0; i < 3 && i < N_SEG; i++) send(8 - 3 * i);
    idle(N_SEG);
    check(out_vld === 1'b1, "pre_rst_out_vld", 64'(out_vld), 64'd1);
    check(y === vy[8], "pre_rst_y", 64'(y), 64'(vy[8]));
    #2;
    arst_n = 1'b0;
    #1;
    check(out_vld === 1'b0, "async_rst_out_vld", 64'(out_vld), 64'd0);
    check(y === '0, "async_rst_y", 64'(y), 64'd0);
    check(cout === 1'b0, "async_rst_cout", 64'(cout), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    arst_n   = 1'b1;
    rdy_mode = 0;
    out_rdy  = 1'b1;
    #1;
    check(in_rdy === 1'b1, "rst_release_in_rdy", 64'(in_rdy), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check(out_vld === 1'b0, "rst_idle_out_vld", 64'(out_vld), 64'd0);
    end

    check(exp_q.size() == 0, "final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
